pad_input_filter: RTL

- Sits directly downstream of the pad frame and consumes the per-pad input vector it produces (data coming from pads).
- Per pad: 2-flop synchronisation, a programmable glitch/debounce filter and edge detection.
- Latches edge events into sticky pending bits and produces a single combined interrupt.
- Feeds the GPIO/peripheral input mux and the SoC event unit.

---
 rtl/pad_input_filter_pkg.sv | 25 ++
 rtl/pad_filter_ch.sv | 82 ++++++++
 rtl/pad_input_filter.sv | 44 ++++
 3 files changed

// File: rtl/pad_input_filter_pkg.sv
// Shared types and helpers for the pad input filter.
package pad_input_filter_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // True when the observed edge is one the pad is configured to report.
  function automatic logic edge_hit(edge_mode_e mode, logic rise, logic fall);
    logic hit;
    case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pad_filter_ch.sv
// One pad channel: 2-flop synchroniser, debounce filter, edge detect and
// sticky pending bit.
module pad_filter_ch
  import pad_input_filter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad_in,
  input  logic             filt_en,
  input  logic [CNT_W-1:0] filt_len,
  input  edge_mode_e       edge_mode,
  input  logic             irq_clr,
  output logic             pad_sync,
  output logic             pad_filt,
  output logic             edge_pend
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_q;
  logic [CNT_W-1:0] cnt;
  logic             filt_d;
  logic             rise;
  logic             fall;
  logic             hit;

  // Two-stage synchroniser for the asynchronous pad input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= 1'b0;
      pad_sync <= 1'b0;
    end else begin
      sync_q   <= pad_in;
      pad_sync <= sync_q;
    end
  end

  // Debounce: the filtered value only follows the synchronised input after
  // it has disagreed for more than filt_len cycles. The increment is only
  // taken while cnt < filt_len, so the counter can never wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      pad_filt <= 1'b0;
    end else if (!filt_en) begin
      cnt      <= '0;
      pad_filt <= pad_sync;
    end else if (pad_sync == pad_filt) begin
      cnt <= '0;
    end else if (cnt >= filt_len) begin
      cnt      <= '0;
      pad_filt <= pad_sync;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Edge qualification against the per-pad mode.
  always_comb begin
    rise = pad_filt & ~filt_d;
    fall = ~pad_filt & filt_d;
    hit  = edge_hit(edge_mode, rise, fall);
  end

  // Delayed filter copy and sticky pending bit; a new edge beats a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_d    <= 1'b0;
      edge_pend <= 1'b0;
    end else begin
      filt_d <= pad_filt;
      if (hit) begin
        edge_pend <= 1'b1;
      end else if (irq_clr) begin
        edge_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pad_input_filter.sv
// Per-pad input conditioning for the pad frame outputs; combines all pending
// edge flags into a single interrupt.
module pad_input_filter
  import pad_input_filter_pkg::*;
#(
  parameter int N_IO  = 56,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_IO-1:0]   pad_in_i,
  input  logic [N_IO-1:0]   filt_en_i,
  input  logic [CNT_W-1:0]  filt_len_i,
  input  logic [2*N_IO-1:0] edge_mode_i,
  input  logic [N_IO-1:0]   irq_clr_i,
  output logic [N_IO-1:0]   pad_sync_o,
  output logic [N_IO-1:0]   pad_filt_o,
  output logic [N_IO-1:0]   edge_pend_o,
  output logic              irq_o
);

  for (genvar g = 0; g < N_IO; g++) begin : g_ch
    pad_filter_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pad_in   (pad_in_i[g]),
      .filt_en  (filt_en_i[g]),
      .filt_len (filt_len_i),
      .edge_mode(edge_mode_e'(edge_mode_i[2*g +: 2])),
      .irq_clr  (irq_clr_i[g]),
      .pad_sync (pad_sync_o[g]),
      .pad_filt (pad_filt_o[g]),
      .edge_pend(edge_pend_o[g])
    );
  end

  // Interrupt is a pure OR of the pending flops.
  always_comb begin
    irq_o = |edge_pend_o;
  end

endmodule
